// File: rtl/ipf_pkg.sv
// Shared definitions for the instruction prefetch unit: default widths,
// reset PC, queue entry layout and the count-width helper.
package ipf_pkg;

    localparam int IPF_ADDR_W = 16;
    localparam int IPF_DATA_W = 16;
    localparam int IPF_DEPTH  = 4;

    localparam logic [IPF_ADDR_W-1:0] IPF_RESET_PC = 16'h0000;

    // A count must be able to hold DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int IPF_CNT_W = cnt_w(IPF_DEPTH);

    typedef struct packed {
        logic [IPF_ADDR_W-1:0] pc;
        logic [IPF_DATA_W-1:0] instr;
    } ipf_entry_t;

endpackage

// File: rtl/ipf_fifo.sv
// Synchronous DEPTH-entry FIFO with flush, push, pop, occupancy count and
// head output. Ports: clk, rst (async, active-high), flush_i, push_i, pop_i,
// data_i, head_o, count_o. Flush overrides push and pop in the same cycle.
module ipf_fifo
    import ipf_pkg::*;
#(
    parameter int W     = IPF_ADDR_W + IPF_DATA_W,
    parameter int DEPTH = IPF_DEPTH,
    localparam int CW   = cnt_w(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            // DEPTH is a power of 2, so pointers wrap on their own.
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // The fetch credit check upstream makes a push into a full queue impossible.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(do_push && !do_pop && cnt_q == FULL)
    );

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction fetch front end: issues sequential reads on memory port 1,
// queues returned words with their PCs and hands them to decode via
// instr_valid/instr_ready; redirect flushes and restarts fetch.
// Ports: clk, reset, mem_addr/mem_read/mem_rdata (memory port 1),
// redirect/redirect_pc, instr_valid/instr/instr_pc/instr_ready (decode).
// Build option IPF_BYPASS_EN: a word returning into an empty queue is shown
// to decode in the same cycle, saving one cycle of latency.
module instr_prefetch_unit
    import ipf_pkg::*;
#(
    parameter int                ADDR_W   = IPF_ADDR_W,
    parameter int                DATA_W   = IPF_DATA_W,
    parameter int                DEPTH    = IPF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = IPF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int CW = cnt_w(DEPTH);
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic [CW:0]   credit;
    logic          issue, ret, byp, push, pop, has_q;

    // Queued words plus the one in flight must never exceed DEPTH.
    assign credit = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue  = !reset && !redirect && (credit < (CW+1)'(DEPTH));

    assign mem_read = issue;
    assign mem_addr = fetch_pc_q;

    // A word returning under a redirect belongs to the old stream: drop it.
    assign ret   = inflight_q && !redirect;
    assign has_q = (count != '0);

`ifdef IPF_BYPASS_EN
    assign byp = ret && !has_q;
`else
    assign byp = 1'b0;
`endif

    assign instr_valid = has_q || byp;
    assign pop         = has_q && instr_ready && !redirect;
    assign push        = ret && !(byp && instr_ready);

    always_comb begin
        {instr_pc, instr} = '0;
        if (byp)        {instr_pc, instr} = {inflight_pc_q, mem_rdata};
        else if (has_q) {instr_pc, instr} = head;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    ipf_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({inflight_pc_q, mem_rdata}),
        .head_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit: directed fetch, stall,
// redirect, wrap and async-reset scenarios against a 1-cycle memory model.
module tb_instr_prefetch_unit;
    import ipf_pkg::*;

`ifdef IPF_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic [15:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    ipf_entry_t  exp_q[$];
    logic [15:0] mem [65536];

    always #5 clk = ~clk;

    instr_prefetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'hA000 + 16'(i);
    end

    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    function automatic ipf_entry_t ent(input logic [15:0] pc);
        ipf_entry_t e;
        e.pc    = pc;
        e.instr = 16'hA000 + pc;
        return e;
    endfunction

    task automatic exp_seq(input logic [15:0] pc0, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(ent(pc0 + 16'(k)));
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready && !redirect) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got pc %h instr %h want none",
                         instr_pc, instr);
            end else begin
                ipf_entry_t e;
                e = exp_q.pop_front();
                if (instr_pc !== e.pc || instr !== e.instr) begin
                    n_err++;
                    $display("FAIL sb_word: got pc %h instr %h want pc %h instr %h",
                             instr_pc, instr, e.pc, e.instr);
                end
            end
        end
    end

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk);
            #2;
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d left want 0", nm, exp_q.size());
            exp_q.delete();
        end
        instr_ready = 1'b0;
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #2;
        reset = 1'b1;
        instr_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic rel();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic run_t1(input string nm);
        exp_q.delete();
        exp_seq(16'h0000, 6);
        instr_ready = 1'b1;
        rel();
        @(negedge clk);
        chk({nm, "_c0_valid"}, instr_valid, 0);
        chk({nm, "_c0_read"}, mem_read, 1);
        chk({nm, "_c0_addr"}, mem_addr, 0);
        @(negedge clk);
        chk({nm, "_c1_valid"}, instr_valid, BYP);
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            chk({nm, "_stream_valid"}, instr_valid, 1);
        end
        drain(nm);
    endtask

    task automatic redir(input logic [15:0] pc, input logic rdy,
                         input int n, input logic chk_v);
        @(posedge clk);
        #2;
        redirect    = 1'b1;
        redirect_pc = pc;
        instr_ready = rdy;
        exp_q.delete();
        exp_seq(pc, n);
        @(negedge clk);
        chk("redir_read_low", mem_read, 0);
        if (chk_v) chk("redir_valid_before", instr_valid, 1);
        @(posedge clk);
        #2;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("redir_first_read", mem_read, 1);
        chk("redir_first_addr", mem_addr, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic mr [10];

        repeat (2) @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_read", mem_read, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);

        // 1: stream from reset
        run_t1("t1");

        // 2: stall until credits run out, then drain in order
        assert_rst();
        rel();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mr[c] = mem_read;
        end
        chk("t2_read_c3", mr[3], 1);
        chk("t2_read_c4", mr[4], 0);
        chk("t2_read_c9", mr[9], 0);
        chk("t2_hold_valid", instr_valid, 1);
        chk("t2_hold_instr", instr, 16'hA000);
        chk("t2_hold_pc", instr_pc, 0);
        exp_seq(16'h0000, 8);
        @(posedge clk);
        #2;
        instr_ready = 1'b1;
        drain("t2");

        // 3: redirect with 3 queued and one in flight
        assert_rst();
        rel();
        repeat (3) @(posedge clk);
        redir(16'h0100, 1'b0, 4, 1'b1);
        drain("t3");

        // 4: redirect coincides with an accepted word
        repeat (3) @(posedge clk);
        redir(16'h0100, 1'b1, 4, 1'b1);
        drain("t4");

        // 5: fetch address wraps
        redir(16'hFFFE, 1'b1, 4, 1'b0);
        drain("t5");

        // 6: async reset mid-stream
        redir(16'h0200, 1'b1, 16, 1'b0);
        repeat (3) @(posedge clk);
        #6;
        chk("t6_pre_valid", instr_valid, 1);
        chk("t6_pre_read", mem_read, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", instr_valid, 0);
        chk("t6_async_read", mem_read, 0);
        chk("t6_async_instr", instr, 0);
        chk("t6_async_pc", instr_pc, 0);
        exp_q.delete();
        run_t1("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
